// File: rtl/pic_core_sync_if.sv
// Host-side bus of the interrupt controller core: acknowledge/EOI strobes in,
// interrupt request and vector strobe out.
interface pic_core_sync_if #(
  parameter int ID_W  = 3,
  parameter int VEC_W = 8
) ();
  logic             inta;
  logic             eoi;
  logic             eoi_specific;
  logic [ID_W-1:0]  eoi_id;
  logic             int_o;
  logic             vec_valid;
  logic [VEC_W-1:0] vector;
  logic             spurious;

  modport master (
    output inta, eoi, eoi_specific, eoi_id,
    input  int_o, vec_valid, vector, spurious
  );

  modport slave (
    input  inta, eoi, eoi_specific, eoi_id,
    output int_o, vec_valid, vector, spurious
  );
endinterface

// File: rtl/pic_core_sync.sv
// Synchronous interrupt controller core: request latching, masking, nested or
// rotating priority, two-pulse acknowledge and normal/specific/automatic EOI.
module pic_core_sync #(
  parameter int N_IRQ = 8,
  parameter int ID_W  = $clog2(N_IRQ),
  parameter int VEC_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [N_IRQ-1:0] irq,
  input  logic             level_mode,
  input  logic             rotate_mode,
  input  logic             aeoi,
  input  logic [N_IRQ-1:0] mask,
  input  logic [VEC_W-1:0] vector_base,
  output logic [N_IRQ-1:0] irr,
  output logic [N_IRQ-1:0] isr,
  pic_core_sync_if.slave   bus
);

  localparam int RW = ID_W + 1;
  localparam logic [RW-1:0]   NONE_RANK = RW'(N_IRQ);
  localparam logic [ID_W-1:0] LAST_ID   = ID_W'(N_IRQ - 1);

  typedef enum logic [1:0] {IDLE, PEND, ACK1} state_t;

  state_t           state_r;
  logic [N_IRQ-1:0] irq_q_r;
  logic [N_IRQ-1:0] irr_r;
  logic [N_IRQ-1:0] isr_r;
  logic [ID_W-1:0]  last_r;
  logic [ID_W-1:0]  sel_id_r;
  logic             spur_r;
  logic             int_o_r;
  logic             vec_valid_r;
  logic             spurious_r;
  logic [VEC_W-1:0] vector_r;

  logic [ID_W-1:0]  start_s;
  logic [RW-1:0]    cand_rank_s;
  logic [RW-1:0]    isr_rank_s;
  logic [ID_W-1:0]  cand_id_s;
  logic [ID_W-1:0]  isr_top_s;
  logic             eligible_s;
  logic [N_IRQ-1:0] isr_set_s;
  logic [N_IRQ-1:0] isr_clr_s;
  logic             last_upd_s;
  logic [ID_W-1:0]  last_nxt_s;
  logic [VEC_W-1:0] vector_nxt_s;

  // (start + off) mod N_IRQ, with both operands already below N_IRQ
  function automatic logic [ID_W-1:0] wrap_idx(input logic [ID_W-1:0] start,
                                               input logic [RW-1:0]   off);
    logic [RW:0] sum;
    sum = (RW+1)'(start) + (RW+1)'(off);
    if (sum >= (RW+1)'(N_IRQ)) begin
      sum = sum - (RW+1)'(N_IRQ);
    end else begin
      sum = sum;
    end
    return ID_W'(sum);
  endfunction

  // Rank (0 = highest priority) of the first set bit scanning from start; N_IRQ if none
  function automatic logic [RW-1:0] first_rank(input logic [N_IRQ-1:0] v,
                                               input logic [ID_W-1:0]  start);
    logic [RW-1:0] r;
    logic          found;
    r     = NONE_RANK;
    found = 1'b0;
    for (int k = 0; k < N_IRQ; k++) begin
      if (!found && v[wrap_idx(start, RW'(k))]) begin
        r     = RW'(k);
        found = 1'b1;
      end else begin
        r = r;
      end
    end
    return r;
  endfunction

  function automatic logic [N_IRQ-1:0] onehot(input logic [ID_W-1:0] id);
    return {{(N_IRQ-1){1'b0}}, 1'b1} << id;
  endfunction

  // Priority resolver and isr/last update terms
  always_comb begin
    isr_clr_s  = '0;
    last_upd_s = 1'b0;
    last_nxt_s = last_r;
    if (rotate_mode) begin
      start_s = wrap_idx(last_r, RW'(1));
    end else begin
      start_s = '0;
    end
    cand_rank_s = first_rank(irr_r & ~mask, start_s);
    isr_rank_s  = first_rank(isr_r, start_s);
    cand_id_s   = wrap_idx(start_s, cand_rank_s);
    isr_top_s   = wrap_idx(start_s, isr_rank_s);
    // an empty isr ranks N_IRQ, so any real candidate beats it
    eligible_s  = (cand_rank_s != NONE_RANK) && (cand_rank_s < isr_rank_s);

    if ((state_r == PEND) && bus.inta && eligible_s) begin
      isr_set_s = onehot(cand_id_s);
    end else begin
      isr_set_s = '0;
    end

    if ((state_r == ACK1) && bus.inta && aeoi && !spur_r) begin
      isr_clr_s  = isr_clr_s | onehot(sel_id_r);
      last_upd_s = 1'b1;
      last_nxt_s = sel_id_r;
    end else begin
      isr_clr_s = isr_clr_s;
    end

    if (bus.eoi && bus.eoi_specific) begin
      if (RW'(bus.eoi_id) < NONE_RANK) begin
        isr_clr_s  = isr_clr_s | onehot(bus.eoi_id);
        last_upd_s = 1'b1;
        last_nxt_s = bus.eoi_id;
      end else begin
        last_upd_s = last_upd_s;
      end
    end else if (bus.eoi && (isr_rank_s != NONE_RANK)) begin
      isr_clr_s  = isr_clr_s | onehot(isr_top_s);
      last_upd_s = 1'b1;
      last_nxt_s = isr_top_s;
    end else begin
      last_upd_s = last_upd_s;
    end

    vector_nxt_s             = vector_base;
    vector_nxt_s[ID_W-1:0]   = sel_id_r;
  end

  // Request/in-service registers and the acknowledge FSM
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r     <= IDLE;
      irq_q_r     <= '0;
      irr_r       <= '0;
      isr_r       <= '0;
      last_r      <= LAST_ID;
      sel_id_r    <= '0;
      spur_r      <= 1'b0;
      int_o_r     <= 1'b0;
      vec_valid_r <= 1'b0;
      spurious_r  <= 1'b0;
      vector_r    <= '0;
    end else begin
      irq_q_r <= irq;
      if (level_mode) begin
        irr_r <= irq;
      end else begin
        irr_r <= (irr_r | (irq & ~irq_q_r)) & ~isr_set_s;
      end
      // set is OR-ed last so an acknowledge wins over a same-cycle EOI
      isr_r <= (isr_r & ~isr_clr_s) | isr_set_s;
      if (last_upd_s) begin
        last_r <= last_nxt_s;
      end else begin
        last_r <= last_r;
      end
      vec_valid_r <= 1'b0;
      spurious_r  <= 1'b0;

      case (state_r)
        IDLE: begin
          int_o_r <= eligible_s;
          if (eligible_s) begin
            state_r <= PEND;
          end else begin
            state_r <= IDLE;
          end
        end
        PEND: begin
          if (bus.inta) begin
            state_r <= ACK1;
            int_o_r <= 1'b0;
            if (eligible_s) begin
              sel_id_r <= cand_id_s;
              spur_r   <= 1'b0;
            end else begin
              sel_id_r <= LAST_ID;
              spur_r   <= 1'b1;
            end
          end else if (!eligible_s) begin
            state_r <= IDLE;
            int_o_r <= 1'b0;
          end else begin
            state_r <= PEND;
          end
        end
        ACK1: begin
          int_o_r <= 1'b0;
          if (bus.inta) begin
            vec_valid_r <= 1'b1;
            spurious_r  <= spur_r;
            vector_r    <= vector_nxt_s;
            state_r     <= IDLE;
          end else begin
            state_r <= ACK1;
          end
        end
        default: begin
          state_r <= IDLE;
          int_o_r <= 1'b0;
        end
      endcase
    end
  end

  assign irr           = irr_r;
  assign isr           = isr_r;
  assign bus.int_o     = int_o_r;
  assign bus.vec_valid = vec_valid_r;
  assign bus.vector    = vector_r;
  assign bus.spurious  = spurious_r;

endmodule

// File: tb/tb_pic_core_sync.sv
// Directed bench for pic_core_sync: 8-line instance for the main scenarios and
// a 16-line instance for the wider-index vector case.
module tb_pic_core_sync;
  logic        clk = 1'b0;
  logic        reset;
  logic [7:0]  irq, mask, vector_base;
  logic        level_mode, rotate_mode, aeoi;
  logic [7:0]  irr, isr;
  logic [15:0] irq16, mask16, irr16, isr16;
  logic [7:0]  base16;
  int          pass_cnt = 0;
  int          chk_cnt  = 0;
  logic [7:0]  exp_ids [3] = '{8'd0, 8'd4, 8'd0};

  pic_core_sync_if #(.ID_W(3), .VEC_W(8)) bus8 ();
  pic_core_sync_if #(.ID_W(4), .VEC_W(8)) bus16 ();

  pic_core_sync #(.N_IRQ(8), .ID_W(3), .VEC_W(8)) dut (
    .clk(clk), .reset(reset), .irq(irq), .level_mode(level_mode),
    .rotate_mode(rotate_mode), .aeoi(aeoi), .mask(mask),
    .vector_base(vector_base), .irr(irr), .isr(isr), .bus(bus8)
  );

  pic_core_sync #(.N_IRQ(16), .ID_W(4), .VEC_W(8)) dut16 (
    .clk(clk), .reset(reset), .irq(irq16), .level_mode(1'b0),
    .rotate_mode(1'b0), .aeoi(1'b0), .mask(mask16),
    .vector_base(base16), .irr(irr16), .isr(isr16), .bus(bus16)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    chk_cnt++;
    assert (obs === exp) pass_cnt++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic pulse_inta();
    bus8.inta = 1'b1;
    step();
    bus8.inta = 1'b0;
  endtask

  task automatic pulse_eoi(input logic spec, input logic [2:0] id);
    bus8.eoi          = 1'b1;
    bus8.eoi_specific = spec;
    bus8.eoi_id       = id;
    step();
    bus8.eoi          = 1'b0;
    bus8.eoi_specific = 1'b0;
    bus8.eoi_id       = 3'd0;
  endtask

  initial begin
    reset = 1'b1; irq = 8'h00; mask = 8'h00; vector_base = 8'hF8;
    level_mode = 1'b0; rotate_mode = 1'b0; aeoi = 1'b0;
    bus8.inta = 1'b0; bus8.eoi = 1'b0; bus8.eoi_specific = 1'b0; bus8.eoi_id = 3'd0;
    bus16.inta = 1'b0; bus16.eoi = 1'b0; bus16.eoi_specific = 1'b0; bus16.eoi_id = 4'd0;
    irq16 = 16'h0000; mask16 = 16'h0000; base16 = 8'hA0;
    step(); step();
    chk("rst_int_o", {31'd0, bus8.int_o}, 32'd0);
    chk("rst_vec_valid", {31'd0, bus8.vec_valid}, 32'd0);
    chk("rst_spurious", {31'd0, bus8.spurious}, 32'd0);
    chk("rst_vector", {24'd0, bus8.vector}, 32'h00);
    chk("rst_irr", {24'd0, irr}, 32'h00);
    chk("rst_isr", {24'd0, isr}, 32'h00);
    reset = 1'b0;
    step();

    // nested priority, single request on bit 4
    irq = 8'h10;
    step();
    chk("edge_irr_k1", {24'd0, irr}, 32'h10);
    chk("edge_int_k1", {31'd0, bus8.int_o}, 32'd0);
    step();
    chk("edge_int_k2", {31'd0, bus8.int_o}, 32'd1);
    pulse_inta();
    chk("ack1_isr", {24'd0, isr}, 32'h10);
    chk("ack1_int_low", {31'd0, bus8.int_o}, 32'd0);
    chk("ack1_irr_clr", {24'd0, irr}, 32'h00);
    pulse_inta();
    chk("ack2_vec_valid", {31'd0, bus8.vec_valid}, 32'd1);
    chk("ack2_vector", {24'd0, bus8.vector}, 32'hFC);
    chk("ack2_spurious", {31'd0, bus8.spurious}, 32'd0);
    step();
    chk("vec_valid_one_cycle", {31'd0, bus8.vec_valid}, 32'd0);
    pulse_eoi(1'b0, 3'd0);
    chk("ns_eoi_isr", {24'd0, isr}, 32'h00);

    // re-enter service of bit 4, then preemption by bit 1 only
    irq = 8'h00; step();
    irq = 8'h10; step(); step();
    chk("re_int", {31'd0, bus8.int_o}, 32'd1);
    pulse_inta(); pulse_inta();
    chk("re_vector", {24'd0, bus8.vector}, 32'hFC);
    step();
    irq = 8'hD0; step(); step(); step();
    chk("low_prio_irr", {24'd0, irr}, 32'hC0);
    chk("low_prio_no_int", {31'd0, bus8.int_o}, 32'd0);
    irq = 8'hD2; step();
    chk("preempt_irr", {24'd0, irr}, 32'hC2);
    step();
    chk("preempt_int", {31'd0, bus8.int_o}, 32'd1);
    pulse_inta();
    chk("preempt_isr", {24'd0, isr}, 32'h12);
    chk("preempt_irr_clr", {24'd0, irr}, 32'hC0);
    pulse_inta();
    chk("preempt_vv", {31'd0, bus8.vec_valid}, 32'd1);
    chk("preempt_vector", {24'd0, bus8.vector}, 32'hF9);
    pulse_eoi(1'b0, 3'd0);
    chk("ns_eoi_top", {24'd0, isr}, 32'h10);

    // bit 3 into service, then specific EOI of 3 only
    irq = 8'hDA; step(); step();
    chk("bit3_int", {31'd0, bus8.int_o}, 32'd1);
    pulse_inta(); pulse_inta();
    chk("bit3_vector", {24'd0, bus8.vector}, 32'hFB);
    chk("bit3_isr", {24'd0, isr}, 32'h18);
    pulse_eoi(1'b1, 3'd3);
    chk("spec_eoi_isr", {24'd0, isr}, 32'h10);

    // masking: bit 2 pending but masked
    mask = 8'hC4;
    pulse_eoi(1'b0, 3'd0);
    chk("mask_isr0", {24'd0, isr}, 32'h00);
    irq = 8'hDE; step(); step(); step();
    chk("mask_irr", {24'd0, irr}, 32'hC4);
    chk("mask_no_int", {31'd0, bus8.int_o}, 32'd0);

    // automatic rotation with AEOI, level mode
    reset = 1'b1; step(); reset = 1'b0;
    mask = 8'h00; level_mode = 1'b1; rotate_mode = 1'b1; aeoi = 1'b1; irq = 8'h11;
    step(); step();
    chk("rot_int", {31'd0, bus8.int_o}, 32'd1);
    for (int i = 0; i < 3; i++) begin
      pulse_inta();
      chk("rot_isr_ack1", {24'd0, isr}, 32'd1 << exp_ids[i]);
      pulse_inta();
      chk("rot_vector", {24'd0, bus8.vector}, {24'd0, 8'hF8 | exp_ids[i]});
      chk("rot_aeoi_isr", {24'd0, isr}, 32'h00);
      step();
      chk("rot_reassert", {31'd0, bus8.int_o}, 32'd1);
    end

    // spurious acknowledge after the level request goes away
    reset = 1'b1; step(); reset = 1'b0;
    rotate_mode = 1'b0; aeoi = 1'b0; irq = 8'h20;
    step(); step();
    chk("spur_int", {31'd0, bus8.int_o}, 32'd1);
    irq = 8'h00; step();
    pulse_inta();
    chk("spur_isr", {24'd0, isr}, 32'h00);
    pulse_inta();
    chk("spur_vv", {31'd0, bus8.vec_valid}, 32'd1);
    chk("spur_flag", {31'd0, bus8.spurious}, 32'd1);
    chk("spur_vector", {24'd0, bus8.vector}, 32'hFF);
    step();
    chk("spur_flag_drop", {31'd0, bus8.spurious}, 32'd0);

    // 16-line instance, request on bit 12
    irq16 = 16'h1000; step(); step();
    chk("n16_int", {31'd0, bus16.int_o}, 32'd1);
    bus16.inta = 1'b1; step(); bus16.inta = 1'b0;
    bus16.inta = 1'b1; step(); bus16.inta = 1'b0;
    chk("n16_vv", {31'd0, bus16.vec_valid}, 32'd1);
    chk("n16_vector", {24'd0, bus16.vector}, 32'hAC);
    chk("n16_isr", {16'd0, isr16}, 32'h1000);

    // reset between the two acknowledge strobes
    level_mode = 1'b0; irq = 8'h00; step();
    irq = 8'h08; step(); step();
    chk("mid_int", {31'd0, bus8.int_o}, 32'd1);
    pulse_inta();
    chk("mid_isr", {24'd0, isr}, 32'h08);
    reset = 1'b1; #1;
    chk("mid_rst_int", {31'd0, bus8.int_o}, 32'd0);
    chk("mid_rst_isr", {24'd0, isr}, 32'h00);
    chk("mid_rst_irr", {24'd0, irr}, 32'h00);
    chk("mid_rst_vector", {24'd0, bus8.vector}, 32'h00);
    irq = 8'h00;
    step();
    reset = 1'b0;
    step();
    pulse_inta();
    chk("mid_no_vv", {31'd0, bus8.vec_valid}, 32'd0);
    chk("mid_isr_idle", {24'd0, isr}, 32'h00);
    step();
    chk("mid_no_vv2", {31'd0, bus8.vec_valid}, 32'd0);

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end
endmodule
